gayle_fifo_drain: RTL
=====================

Name: gayle_fifo_drain

Overview:
- Read-side engine for the Gayle sector FIFO.
- On a start command it pops whole 256-word sectors from the FIFO and streams each word to the host I/O side over a valid/ready handshake.
- Counts words and sectors, and cross-checks the FIFO's last-word flag against its own word counter.
- Sits between the Gayle IDE register/FIFO block and the host transfer channel, in the clk7_en-qualified bus-clock domain.

Parameters:
- WORDS_LOG2, 8, log2 of words per sector (256 words = 512 bytes); sets word counter width.
- SEC_W, 8, width of the sector_count input; 0 means 2**SEC_W sectors.

Ports:
- clk  in  1  bus clock.
- reset_n  in  1  asynchronous active-low reset.
- clk7_en  in  1  clock enable; every register update, handshake and pulse is qualified by it.
- start  in  1  begin a transfer; sampled in IDLE only.
- abort  in  1  terminate the transfer; returns to IDLE next enabled cycle.
- sector_count  in  SEC_W  number of sectors, latched at start.
- fifo_data  in  16  FIFO read data (registered copy of the word at the read pointer).
- fifo_empty  in  1  FIFO empty flag.
- fifo_last  in  1  FIFO read pointer is at word 255 of a sector.
- fifo_rd  out  1  pop one word; single enabled-cycle pulse.
- tx_data  out  16  word to host.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  host accepts; transfer happens when tx_valid & tx_ready & clk7_en.
- busy  out  1  high in every state except IDLE.
- sector_done  out  1  one-cycle pulse when a sector's final word is accepted.
- done  out  1  one-cycle pulse when the final word of the final sector is accepted.
- sync_err  out  1  sticky: fifo_last disagreed with the internal word counter.

Behaviour:
- Async reset:
  - state=IDLE.
  - fifo_rd, tx_valid, busy, sector_done, done, sync_err all 0.
  - tx_data=0, counters=0.
- No register changes when clk7_en=0; outputs hold.
- IDLE:
  - On start, latch sectors_left = sector_count (0 → 2**SEC_W), clear word_cnt, clear sync_err.
  - Go to WAIT_NE.
- WAIT_NE: if !fifo_empty, go to SETTLE; otherwise stay.
- SETTLE:
  - Spends exactly one enabled cycle so fifo_data reflects the current read pointer.
  - Then go to CAPTURE.
- CAPTURE (one enabled cycle):
  - tx_data <= fifo_data; fifo_rd=1 in this cycle only.
  - Compare fifo_last with (word_cnt == all-ones); on mismatch set sync_err. The transfer continues regardless.
  - Go to SEND with tx_valid=1.
- SEND:
  - Hold tx_valid and tx_data stable until accepted.
  - On accept: tx_valid=0 and word_cnt wraps modulo 2**WORDS_LOG2.
  - If word_cnt was all-ones: pulse sector_done and decrement sectors_left.
    - If sectors_left was 1: pulse done in the same cycle and go to IDLE.
  - Otherwise go to WAIT_NE.
- Throughput: at most one word per 4 enabled cycles. This is acceptable against the 7 MHz enable.
- FIFO empty mid-sector: stall in WAIT_NE indefinitely. No timeout.
- abort:
  - Has priority over all transitions in any non-IDLE state; next state is IDLE.
  - tx_valid drops, no fifo_rd is issued, no sector_done/done pulse.
  - An abort in CAPTURE suppresses that cycle's fifo_rd.
  - Counters are not cleared until the next start.
- start while busy: ignored.
- start and abort together in IDLE: abort wins; the block stays in IDLE.
- fifo_rd is never asserted while fifo_empty=1.

Decomposition:
- Shared gayle package holds:
  - state enum (IDLE, WAIT_NE, SETTLE, CAPTURE, SEND);
  - SECTOR_WORDS constant = 256;
  - word/sector width constants.
- Single module with no sub-module. The counter pair is small enough to stay inline.

Test Plan:
- Reset mid-transfer: assert reset_n=0 during SEND → all outputs 0 immediately; next start behaves normally.
- One sector, FIFO preloaded with 256 words 0x0000..0x00FF, tx_ready=1, sector_count=1:
  - 256 fifo_rd pulses and 256 tx words in order;
  - sector_done and done pulse together on word 0x00FF; busy falls next cycle; sync_err=0.
- Backpressure: tx_ready low for 5 enabled cycles on word 10 → tx_data and tx_valid stable, no extra fifo_rd, word 11 follows after ready.
- Starved FIFO: sector_count=2, 300 words available → stall in WAIT_NE after word 300, with sector_done pulsed once at word 256; refill 212 words → done on word 512.
- Misaligned last: force fifo_last=1 at word 100 → sync_err=1 from the capture cycle; the transfer still completes; sync_err is cleared at the next start.
- abort in CAPTURE of word 3 → no fifo_rd that cycle, tx_valid=0, busy=0 next enabled cycle, no done pulse.
- sector_count=0: runs 256 sectors (65536 words) before done.

Source files
------------

// File: rtl/gayle_fifo_drain_pkg.sv
// Shared definitions for the Gayle sector FIFO read-side drain engine.
package gayle_fifo_drain_pkg;

  // Drain engine states; one word moves through WAIT_NE..SEND per loop.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_NE = 3'd1,
    SETTLE  = 3'd2,
    CAPTURE = 3'd3,
    SEND    = 3'd4
  } drain_state_t;

  // One IDE sector is 256 16-bit words (512 bytes).
  localparam int SECTOR_WORDS   = 256;
  localparam int WORD_W         = 16;
  localparam int WORDS_LOG2_DEF = 8;
  localparam int SEC_W_DEF      = 8;

endpackage

// File: rtl/gayle_fifo_drain.sv
// Gayle sector FIFO drain: pops whole sectors word by word and streams them
// to the host channel, tracking word/sector position and checking the FIFO's
// last-word flag against the internal word counter.
//
// Host handshake: tx_valid rises with tx_data in the same enabled cycle and
// both stay stable until a word is transferred; a transfer happens on an
// enabled clock edge where tx_valid & tx_ready & clk7_en are all high, after
// which tx_valid drops. tx_ready may be changed freely by the host.
module gayle_fifo_drain
  import gayle_fifo_drain_pkg::*;
#(
  parameter int WORDS_LOG2 = WORDS_LOG2_DEF,
  parameter int SEC_W      = SEC_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clk7_en,
  input  logic             start,
  input  logic             abort,
  input  logic [SEC_W-1:0] sector_count,
  input  logic [15:0]      fifo_data,
  input  logic             fifo_empty,
  input  logic             fifo_last,
  output logic             fifo_rd,
  output logic [15:0]      tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy,
  output logic             sector_done,
  output logic             done,
  output logic             sync_err,
  output logic [2:0]       state_dbg
);

  localparam logic [WORDS_LOG2-1:0] WORD_MAX = '1;
  localparam logic [SEC_W:0]        SEC_ONE  = (SEC_W+1)'(1);

  drain_state_t          state;
  drain_state_t          state_next;
  logic [WORDS_LOG2-1:0] word_cnt;
  logic [SEC_W:0]        sectors_left;
  logic                  word_last;
  logic                  sector_last;
  logic                  abort_now;

  assign word_last   = (word_cnt == WORD_MAX);
  assign sector_last = (sectors_left == SEC_ONE);
  // abort only acts outside IDLE; in IDLE it merely masks start.
  assign abort_now   = abort && (state != IDLE);
  assign busy        = (state != IDLE);
  assign state_dbg   = state;

  // Next state plus the single-enabled-cycle strobes (fifo_rd, sector_done, done).
  always_comb begin
    state_next  = state;
    fifo_rd     = 1'b0;
    sector_done = 1'b0;
    done        = 1'b0;
    if (abort_now) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) state_next = WAIT_NE;
        end
        WAIT_NE: begin
          if (!fifo_empty) state_next = SETTLE;
        end
        SETTLE: begin
          state_next = CAPTURE;
        end
        CAPTURE: begin
          state_next = SEND;
          // The empty guard keeps a pop from ever reaching an empty FIFO.
          fifo_rd    = clk7_en && !fifo_empty;
        end
        SEND: begin
          if (tx_ready) begin
            state_next = WAIT_NE;
            if (word_last) begin
              sector_done = clk7_en;
              if (sector_last) begin
                done       = clk7_en;
                state_next = IDLE;
              end
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // State register, advancing only on enabled cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else if (clk7_en) begin
      state <= state_next;
    end
  end

  // Word latch, handshake flag, counters and the sticky sync error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_data      <= '0;
      tx_valid     <= 1'b0;
      word_cnt     <= '0;
      sectors_left <= '0;
      sync_err     <= 1'b0;
    end else if (clk7_en) begin
      if (abort_now) begin
        // Counters intentionally survive an abort until the next start.
        tx_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              // A count of zero means the full 2**SEC_W sectors.
              sectors_left <= (sector_count == '0) ? {1'b1, {SEC_W{1'b0}}}
                                                   : {1'b0, sector_count};
              word_cnt     <= '0;
              sync_err     <= 1'b0;
            end
          end
          CAPTURE: begin
            tx_data  <= fifo_data;
            tx_valid <= 1'b1;
            // The FIFO's last flag must line up with our word 255.
            if (fifo_last != word_last) sync_err <= 1'b1;
          end
          SEND: begin
            if (tx_ready) begin
              tx_valid <= 1'b0;
              word_cnt <= word_cnt + WORDS_LOG2'(1);
              if (word_last) sectors_left <= sectors_left - SEC_ONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
